// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// 34 cycles from start to done; busy stalls decode, flush aborts in-flight work.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   opa_q, opb_q, araw_q;
   logic [WIDTH-1:0]   acc_q, quo_q;
   logic [WIDTH-1:0]   acc_d, quo_d;
   logic               neg_res_q, neg_rem_q, divz_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               busy_q, done_q;

   logic               sgn_a, sgn_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;

   // Signed ops iterate on magnitudes; signs are reapplied in FIX.
   assign sgn_a = ~op[0] & a[WIDTH-1];
   assign sgn_b = ~op[0] & b[WIDTH-1];
   assign mag_a = sgn_a ? -a : a;
   assign mag_b = sgn_b ? -b : b;

   always_comb begin
      acc_d    = acc_q;
      quo_d    = quo_q;
      mul_sum  = '0;
      div_sh   = '0;
      div_diff = '0;
      if (!op_q[1]) begin
         // {acc,quo} is the product shift register; quo's LSB is the next multiplier bit.
         mul_sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opa_q} : '0);
         acc_d   = mul_sum[WIDTH:1];
         quo_d   = {mul_sum[0], quo_q[WIDTH-1:1]};
      end else begin
         div_sh   = {acc_q, quo_q[WIDTH-1]};
         div_diff = div_sh - {1'b0, opb_q};
         if (!div_diff[WIDTH]) begin
            acc_d = div_diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = div_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_comb begin
      prod     = {acc_q, quo_q};
      fix_hi_d = '0;
      fix_lo_d = '0;
      if (!op_q[1]) begin
         if (neg_res_q) prod = -prod;
         fix_hi_d = prod[2*WIDTH-1:WIDTH];
         fix_lo_d = prod[WIDTH-1:0];
      end else if (divz_q) begin
         fix_hi_d = araw_q;
         fix_lo_d = '1;
      end else begin
         fix_lo_d = neg_res_q ? -quo_q : quo_q;
         fix_hi_d = neg_rem_q ? -acc_q : acc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         araw_q    <= '0;
         acc_q     <= '0;
         quo_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         divz_q    <= 1'b0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!flush) begin
                  if (start) begin
                     op_q      <= op;
                     opa_q     <= mag_a;
                     opb_q     <= mag_b;
                     araw_q    <= a;
                     acc_q     <= '0;
                     quo_q     <= op[1] ? mag_a : mag_b;
                     neg_res_q <= sgn_a ^ sgn_b;
                     neg_rem_q <= sgn_a;
                     divz_q    <= op[1] & (b == '0);
                     cnt_q     <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= CALC;
                  end else begin
                     if (hi_we) hi_q <= wdata;
                     if (lo_we) lo_q <= wdata;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  acc_q <= acc_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
               end
            end
            FIX: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
               if (!flush) begin
                  hi_q   <= fix_hi_d;
                  lo_q   <= fix_lo_d;
                  done_q <= 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
